// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Bundles every handshake and bus signal of the shared-memory arbiter.
//   slave  : seen by the arbiter (requests and memory read data in,
//            acks, read data, memory strobes and status out)
//   master : seen by the requesters and the memory (the mirror image)
// Port summary:
//   i_req, i_addr, i_ack, i_rdata                : instruction-fetch port
//   d_req, d_we, d_addr, d_wdata, d_ack, d_rdata : data load/store port
//   mem_en, mem_we, mem_addr, mem_wdata, mem_rdata : shared memory
//   busy, grant_d                                : arbiter status
interface mem_arbiter_if #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 16
);
  logic                  i_req;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  i_ack;
  logic [WIDTH-1:0]      i_rdata;
  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [WIDTH-1:0]      d_wdata;
  logic                  d_ack;
  logic [WIDTH-1:0]      d_rdata;
  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0]      mem_wdata;
  logic [WIDTH-1:0]      mem_rdata;
  logic                  busy;
  logic                  grant_d;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr,
           mem_wdata, busy, grant_d
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr,
           mem_wdata, busy, grant_d
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one fixed-latency memory between the instruction-fetch port and
// the data load/store port. Each access runs IDLE -> ISSUE -> WAIT -> ACK,
// and every output is registered on the rising edge of clock so that the
// falling-edge datapath registers see stable enables and data.
// Parameters:
//   WIDTH      : data word width
//   ADDR_WIDTH : address width
//   LATENCY    : memory read latency in cycles (1 or more)
// Ports:
//   clock : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : mem_arbiter_if.slave (requester handshakes, memory bus, status)
// Build option:
//   MEM_ARBITER_ROUND_ROBIN_EN : when defined, simultaneous requests are
//   granted to the port not granted last; otherwise data always wins.
module mem_arbiter #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int LATENCY    = 2
) (
  input logic          clock,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  if (LATENCY < 1) begin : gLatencyCheck
    $error("mem_arbiter: LATENCY must be 1 or greater");
  end

  if (WIDTH < 1 || ADDR_WIDTH < 1) begin : gWidthCheck
    $error("mem_arbiter: WIDTH and ADDR_WIDTH must be positive");
  end

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] WAIT_LOAD = CW'((LATENCY > 0) ? LATENCY - 1 : 0);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t        state;
  logic [CW-1:0] waitCount;
  logic          latchedWe;
  logic          grantData;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic          lastGrantD;
`endif

  // Pick the winner among the requests currently presented. Only used in
  // IDLE; a lone request always wins, only contested requests depend on
  // the arbitration mode.
  always_comb begin
    grantData = 1'b0;
    if (bus.d_req && bus.i_req) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      grantData = ~lastGrantD;
`else
      grantData = 1'b1;
`endif
    end else if (bus.d_req) begin
      grantData = 1'b1;
    end
  end

  // Transaction sequencer. The winner's address, write flag and data are
  // loaded straight into the registered memory outputs at the grant edge,
  // so they are already on the bus during ISSUE. mem_we is only high in
  // ISSUE; latchedWe remembers the direction for the capture decision.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      waitCount   <= '0;
      latchedWe   <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.i_ack     <= 1'b0;
      bus.d_ack     <= 1'b0;
      bus.i_rdata   <= '0;
      bus.d_rdata   <= '0;
      bus.busy      <= 1'b0;
      bus.grant_d   <= 1'b0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      lastGrantD  <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.i_req || bus.d_req) begin
            bus.grant_d <= grantData;
            bus.busy    <= 1'b1;
            bus.mem_en  <= 1'b1;
            if (grantData) begin
              bus.mem_addr  <= bus.d_addr;
              bus.mem_wdata <= bus.d_wdata;
              bus.mem_we    <= bus.d_we;
              latchedWe     <= bus.d_we;
            end else begin
              bus.mem_addr  <= bus.i_addr;
              bus.mem_we    <= 1'b0;
              latchedWe     <= 1'b0;
            end
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            lastGrantD <= grantData;
`endif
            state <= ISSUE;
          end
        end
        ISSUE: begin
          bus.mem_en <= 1'b0;
          bus.mem_we <= 1'b0;
          waitCount  <= WAIT_LOAD;
          state      <= WAIT;
        end
        WAIT: begin
          if (waitCount != '0) begin
            waitCount <= waitCount - 1'b1;
          end else begin
            // Writes leave both read-data registers untouched.
            if (!latchedWe) begin
              if (bus.grant_d) bus.d_rdata <= bus.mem_rdata;
              else             bus.i_rdata <= bus.mem_rdata;
            end
            if (bus.grant_d) bus.d_ack <= 1'b1;
            else             bus.i_ack <= 1'b1;
            state <= ACK;
          end
        end
        ACK: begin
          bus.i_ack <= 1'b0;
          bus.d_ack <= 1'b0;
          bus.busy  <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Exercises mem_arbiter with LATENCY=2 against a small memory model, plus
// LATENCY=1 and LATENCY=5 instances for the timing sweep.
module tb_mem_arbiter;
  localparam int W  = 16;
  localparam int AW = 16;

  logic clock = 1'b0;
  logic reset;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mem_arbiter_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus  ();
  mem_arbiter_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus1 ();
  mem_arbiter_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus5 ();

  mem_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW), .LATENCY(2)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );
  mem_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW), .LATENCY(1)) u1 (
    .clock(clock), .reset(reset), .bus(bus1)
  );
  mem_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW), .LATENCY(5)) u5 (
    .clock(clock), .reset(reset), .bus(bus5)
  );

  // Memory model for the LATENCY=2 instance: it samples the strobe, shows
  // garbage for one cycle, then presents the read word, so read data is
  // only valid from the edge the arbiter is supposed to capture on.
  logic [15:0] memArray [0:1023];
  logic [15:0] memRead = 16'h0000;
  logic [15:0] pendData = 16'h0000;
  logic        pending = 1'b0;

  always @(posedge clock) begin
    pending <= 1'b0;
    if (pending) memRead <= pendData;
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        memArray[bus.mem_addr[9:0]] <= bus.mem_wdata;
      end else begin
        pendData <= memArray[bus.mem_addr[9:0]];
        pending  <= 1'b1;
        memRead  <= 16'hDEAD;
      end
    end
  end

  assign bus.mem_rdata  = memRead;
  assign bus1.mem_rdata = 16'hA5A5;
  assign bus5.mem_rdata = 16'hA5A5;

  typedef struct {
    logic        isData;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] expIRdata;
    logic [15:0] expDRdata;
  } vec_t;

  vec_t vecs [8];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Run one single-requester transaction and check the issue cycle, the
  // req-to-ack latency, the ack pulse and both read-data registers.
  task automatic applyStimulus(input vec_t v);
    int   cycles;
    int   enHigh;
    logic gotAck;
    bus.i_req   = !v.isData;
    bus.d_req   = v.isData;
    bus.d_we    = v.we;
    bus.i_addr  = v.isData ? 16'h0F00 : v.addr;
    bus.d_addr  = v.isData ? v.addr : 16'h0F00;
    bus.d_wdata = v.wdata;
    cycles = 0;
    enHigh = 0;
    gotAck = 1'b0;
    while (!gotAck && cycles < 20) begin
      @(posedge clock); #1;
      cycles++;
      if (bus.mem_en) begin
        enHigh++;
        checkOutput("issue_we",    32'(bus.mem_we),   32'(v.we));
        checkOutput("issue_addr",  32'(bus.mem_addr), 32'(v.addr));
        checkOutput("issue_grant", 32'(bus.grant_d),  32'(v.isData));
        checkOutput("issue_busy",  32'(bus.busy),     32'd1);
        if (v.we) checkOutput("issue_wdata", 32'(bus.mem_wdata), 32'(v.wdata));
      end
      gotAck = v.isData ? bus.d_ack : bus.i_ack;
    end
    checkOutput("ack_seen",   32'(gotAck), 32'd1);
    checkOutput("req_to_ack", 32'(cycles - 1), 32'd3);
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    checkOutput("en_pulses", 32'(enHigh), 32'd1);
    checkOutput("other_ack", 32'(v.isData ? bus.i_ack : bus.d_ack), 32'd0);
    checkOutput("i_rdata",   32'(bus.i_rdata), 32'(v.expIRdata));
    checkOutput("d_rdata",   32'(bus.d_rdata), 32'(v.expDRdata));
    @(posedge clock); #1;
    checkOutput("ack_pulse", 32'(bus.i_ack | bus.d_ack), 32'd0);
    checkOutput("busy_end",  32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic expOrder [4];
    int   nAck;
    int   lastAckCycle;
    int   cyc;
    int   n1, n5, a1First, a1Second, a5First, a5Second;

    for (int i = 0; i < 1024; i++) memArray[i] = 16'h0000;
    memArray[10'h010] = 16'hBEEF;
    memArray[10'h020] = 16'hCAFE;
    memArray[10'h030] = 16'h4321;
    memArray[10'h040] = 16'h5A5A;
    memArray[10'h3FF] = 16'h0F0F;

    vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 16'h0000};
    vecs[1] = '{1'b1, 1'b1, 16'h0200, 16'h1234, 16'hBEEF, 16'h0000};
    vecs[2] = '{1'b1, 1'b0, 16'h0200, 16'h0000, 16'hBEEF, 16'h1234};
    vecs[3] = '{1'b0, 1'b0, 16'h0020, 16'h0000, 16'hCAFE, 16'h1234};
    vecs[4] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 16'hCAFE, 16'h5A5A};
    vecs[5] = '{1'b1, 1'b1, 16'h0040, 16'h7777, 16'hCAFE, 16'h5A5A};
    vecs[6] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 16'hCAFE, 16'h7777};
    vecs[7] = '{1'b0, 1'b0, 16'h03FF, 16'h0000, 16'h0F0F, 16'h7777};

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    expOrder = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    expOrder = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif

    bus1.i_req = 1'b0; bus1.i_addr = 16'h0001; bus1.d_req = 1'b0;
    bus1.d_we  = 1'b0; bus1.d_addr = 16'h0000; bus1.d_wdata = 16'h0000;
    bus5.i_req = 1'b0; bus5.i_addr = 16'h0005; bus5.d_req = 1'b0;
    bus5.d_we  = 1'b0; bus5.d_addr = 16'h0000; bus5.d_wdata = 16'h0000;

    // Reset with both requests high: everything must read zero.
    reset = 1'b1;
    bus.i_req = 1'b1; bus.d_req = 1'b1; bus.d_we = 1'b0;
    bus.i_addr = 16'h0010; bus.d_addr = 16'h0030; bus.d_wdata = 16'h0000;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst_mem_en",    32'(bus.mem_en),    32'd0);
    checkOutput("rst_mem_we",    32'(bus.mem_we),    32'd0);
    checkOutput("rst_i_ack",     32'(bus.i_ack),     32'd0);
    checkOutput("rst_d_ack",     32'(bus.d_ack),     32'd0);
    checkOutput("rst_busy",      32'(bus.busy),      32'd0);
    checkOutput("rst_grant_d",   32'(bus.grant_d),   32'd0);
    checkOutput("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
    checkOutput("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    checkOutput("rst_i_rdata",   32'(bus.i_rdata),   32'd0);
    checkOutput("rst_d_rdata",   32'(bus.d_rdata),   32'd0);

    // Both requests held through four transactions.
    reset = 1'b0;
    nAck = 0; lastAckCycle = 0; cyc = 0;
    while (nAck < 4 && cyc < 40) begin
      @(posedge clock); #1;
      cyc++;
      if (bus.i_ack || bus.d_ack) begin
        checkOutput("contend_grant",   32'(bus.d_ack), 32'(expOrder[nAck]));
        checkOutput("contend_one_ack", 32'(bus.i_ack & bus.d_ack), 32'd0);
        if (nAck > 0) checkOutput("contend_spacing", 32'(cyc - lastAckCycle), 32'd5);
        else          checkOutput("contend_first",   32'(cyc - 1), 32'd3);
        lastAckCycle = cyc;
        nAck++;
      end
    end
    checkOutput("contend_count",   32'(nAck), 32'd4);
    checkOutput("contend_d_rdata", 32'(bus.d_rdata), 32'h4321);

    // Drop the data request: the held fetch must now be served.
    bus.d_req = 1'b0;
    cyc = 0;
    while (!bus.i_ack && cyc < 20) begin
      @(posedge clock); #1;
      cyc++;
    end
    checkOutput("after_drop_i_ack",   32'(bus.i_ack), 32'd1);
    checkOutput("after_drop_i_rdata", 32'(bus.i_rdata), 32'hBEEF);
    bus.i_req = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("after_drop_idle", 32'(bus.busy), 32'd0);

    // Reset clears the read-data registers.
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checkOutput("rst2_i_rdata", 32'(bus.i_rdata), 32'd0);
    checkOutput("rst2_d_rdata", 32'(bus.d_rdata), 32'd0);

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    // Reset during WAIT of a fetch: no ack, IDLE next cycle, then retry.
    bus.i_req = 1'b1; bus.i_addr = 16'h0020;
    @(posedge clock); #1;
    @(posedge clock); #1;
    checkOutput("wait_busy",   32'(bus.busy),   32'd1);
    checkOutput("wait_mem_en", 32'(bus.mem_en), 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checkOutput("abort_i_ack", 32'(bus.i_ack), 32'd0);
    checkOutput("abort_busy",  32'(bus.busy),  32'd0);
    applyStimulus('{1'b0, 1'b0, 16'h0020, 16'h0000, 16'hCAFE, 16'h0000});

    // Latency sweep with fetch requests held on the LATENCY=1 and =5 units.
    bus1.i_req = 1'b1; bus5.i_req = 1'b1;
    n1 = 0; n5 = 0; cyc = 0;
    a1First = 0; a1Second = 0; a5First = 0; a5Second = 0;
    while ((n1 < 2 || n5 < 2) && cyc < 40) begin
      @(posedge clock); #1;
      cyc++;
      if (bus1.i_ack) begin
        if (n1 == 0) a1First = cyc; else if (n1 == 1) a1Second = cyc;
        n1++;
      end
      if (bus5.i_ack) begin
        if (n5 == 0) a5First = cyc; else if (n5 == 1) a5Second = cyc;
        n5++;
      end
    end
    bus1.i_req = 1'b0; bus5.i_req = 1'b0;
    checkOutput("l1_acks",    32'(n1 >= 2), 32'd1);
    checkOutput("l5_acks",    32'(n5 >= 2), 32'd1);
    checkOutput("l1_latency", 32'(a1First - 1), 32'd2);
    checkOutput("l1_spacing", 32'(a1Second - a1First), 32'd4);
    checkOutput("l5_latency", 32'(a5First - 1), 32'd6);
    checkOutput("l5_spacing", 32'(a5Second - a5First), 32'd8);
    checkOutput("l1_rdata",   32'(bus1.i_rdata), 32'hA5A5);
    checkOutput("l5_rdata",   32'(bus5.i_rdata), 32'hA5A5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
